// File: rtl/echo_pkg.sv
// Shared types and helpers for the echo processor: FSM state encoding,
// offset-binary midpoint and signed saturation.
package echo_pkg;

   typedef enum logic [2:0] {IDLE, RD, WT, CALC, WR} state_t;

   // Offset-binary midpoint for a w-bit sample (2^(w-1)).
   function automatic int offset_of(input int w);
      return 1 << (w - 1);
   endfunction

   // Clip v into the signed w-bit range.
   function automatic int saturate(input int v, input int w);
      int hi;
      int lo;
      hi = (1 << (w - 1)) - 1;
      lo = -(1 << (w - 1));
      if (v > hi) return hi;
      else if (v < lo) return lo;
      else return v;
   endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port echo history RAM, DATA_W x 2^ADDR_W, registered read
// (one cycle latency). Contents are intentionally not reset.
module delay_ram #(
   parameter int DATA_W = 10,
   parameter int ADDR_W = 13
) (
   input  logic              sysclk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Write port.
   always_ff @(posedge sysclk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Registered read port.
   always_ff @(posedge sysclk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/echo_proc.sv
// Audio echo processor: y = sat(x + (x[n-delay] >>> gain_sh)) on offset-binary
// samples, with a circular history in delay_ram.
// Build option: define ECHO_FEEDBACK_EN to store y instead of x in the
// history (recursive decaying echo); bypass always stores x.
//
// state | meaning
// IDLE  | waiting for data_valid, latches sample and controls
// RD    | RAM read issued at wr_ptr - delay
// WT    | RAM read latency
// CALC  | echo term, sum and saturation registered into y_reg
// WR    | history write, pointer/fill update, output strobe
module echo_proc
   import echo_pkg::*;
#(
   parameter int DATA_W = 10,
   parameter int ADDR_W = 13
) (
   input  logic              sysclk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   input  logic [ADDR_W-1:0] delay,
   input  logic [1:0]        gain_sh,
   input  logic              bypass,
   output logic [DATA_W-1:0] data_out,
   output logic              out_valid,
   output logic              overrun
);

   localparam logic [DATA_W-1:0] OFFSET = DATA_W'(offset_of(DATA_W));

   state_t state, nxt;

   logic [ADDR_W-1:0]        wr_ptr, fill_cnt, lat_delay, rd_addr;
   logic [1:0]               lat_gain;
   logic                     lat_bypass;
   logic [DATA_W-1:0]        lat_raw, rd_data, wr_data;
   logic signed [DATA_W-1:0] lat_x, echo, y_reg, y_sat;
   logic signed [DATA_W:0]   sum;
   logic                     we, rd_en;

   assign rd_addr = wr_ptr - lat_delay;
   assign rd_en   = (state == RD);
   // Reset during WR must abort the write as well as the strobe.
   assign we      = (state == WR) && rst_n;

`ifdef ECHO_FEEDBACK_EN
   assign wr_data = lat_bypass ? lat_x : y_reg;
`else
   assign wr_data = lat_x;
`endif

   delay_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
      .sysclk  (sysclk),
      .wr_en   (we),
      .wr_addr (wr_ptr),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // State register.
   always_ff @(posedge sysclk) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   // Next-state: fixed five-cycle walk once a sample is accepted.
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (data_valid) nxt = RD;
         RD:      nxt = WT;
         WT:      nxt = CALC;
         CALC:    nxt = WR;
         WR:      nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Echo term is suppressed until the addressed history word has been written.
   always_comb begin
      echo = '0;
      if (lat_delay != '0 && fill_cnt >= lat_delay)
         echo = $signed(rd_data) >>> lat_gain;
      sum   = {lat_x[DATA_W-1], lat_x} + {echo[DATA_W-1], echo};
      y_sat = DATA_W'(saturate(int'(sum), DATA_W));
   end

   // Sample latch, pointers, output register and sticky overrun.
   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         fill_cnt   <= '0;
         data_out   <= OFFSET;
         out_valid  <= 1'b0;
         overrun    <= 1'b0;
         lat_raw    <= '0;
         lat_x      <= '0;
         lat_delay  <= '0;
         lat_gain   <= '0;
         lat_bypass <= 1'b0;
         y_reg      <= '0;
      end else begin
         out_valid <= 1'b0;
         if (data_valid && state != IDLE) overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (data_valid) begin
                  lat_raw    <= data_in;
                  lat_x      <= data_in - OFFSET;
                  lat_delay  <= delay;
                  lat_gain   <= gain_sh;
                  lat_bypass <= bypass;
               end
            end
            CALC: y_reg <= y_sat;
            WR: begin
               wr_ptr    <= wr_ptr + ADDR_W'(1);
               if (fill_cnt != '1) fill_cnt <= fill_cnt + ADDR_W'(1);
               out_valid <= 1'b1;
               data_out  <= lat_bypass ? lat_raw : ($unsigned(y_reg) + OFFSET);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_echo_proc.sv
// Self-checking bench for echo_proc (ADDR_W=4 build so pointer wrap is reachable).
// Expected outputs are queued when a sample is driven and popped when out_valid fires.
module tb_echo_proc;

   logic       sysclk;
   logic       rst_n;
   logic [9:0] data_in;
   logic       data_valid;
   logic [3:0] delay;
   logic [1:0] gain_sh;
   logic       bypass;
   logic [9:0] data_out;
   logic       out_valid;
   logic       overrun;

   int n_cmp = 0;
   int n_bad = 0;
   logic [9:0] exp_q[$];

   echo_proc #(.DATA_W(10), .ADDR_W(4)) dut (
      .sysclk     (sysclk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .data_valid (data_valid),
      .delay      (delay),
      .gain_sh    (gain_sh),
      .bypass     (bypass),
      .data_out   (data_out),
      .out_valid  (out_valid),
      .overrun    (overrun)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1);
   end

   task automatic do_reset();
      @(negedge sysclk);
      rst_n = 1'b0;
      data_valid = 1'b0;
      repeat (3) @(negedge sysclk);
      rst_n = 1'b1;
   endtask

   // Pulse one sample, then wait (bounded) for out_valid; lat = cycles after
   // the accepting edge, -1 on timeout.
   task automatic drive_sample(input logic [9:0] din, output logic [9:0] got, output int lat);
      @(negedge sysclk);
      data_in = din;
      data_valid = 1'b1;
      @(negedge sysclk);
      data_valid = 1'b0;
      lat = -1;
      got = 'x;
      for (int k = 0; k <= 8; k++) begin
         if (out_valid) begin
            lat = k;
            got = data_out;
            break;
         end
         @(negedge sysclk);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (data_out !== 10'd512) begin
         n_bad++;
         $display("FAIL reset_data_out got %0d want 512", data_out);
      end
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_out_valid got %b want 0", out_valid);
      end
      n_cmp++;
      if (overrun !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_overrun got %b want 0", overrun);
      end
   endtask

   task automatic test_impulse();
      logic [9:0] got, want, din;
      int lat;
      do_reset();
      delay = 4'd4; gain_sh = 2'd1; bypass = 1'b0;
      for (int i = 0; i < 16; i++) begin
         din = (i == 0) ? 10'd712 : 10'd512;
         want = 10'd512;
         if (i == 0) want = 10'd712;
         if (i == 4) want = 10'd612;
`ifdef ECHO_FEEDBACK_EN
         if (i == 8)  want = 10'd562;
         if (i == 12) want = 10'd537;
`endif
         exp_q.push_back(want);
         drive_sample(din, got, lat);
         want = exp_q.pop_front();
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL impulse[%0d] got %0d want %0d (lat %0d)", i, got, want, lat);
         end
      end
   endtask

   task automatic test_saturation();
      logic [9:0] got, want;
      int lat;
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         delay = 4'd1; gain_sh = 2'd0; bypass = 1'b0;
         for (int i = 0; i < 5; i++) begin
            exp_q.push_back(pass == 0 ? 10'd1023 : 10'd0);
            drive_sample(pass == 0 ? 10'd1023 : 10'd0, got, lat);
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
               n_bad++;
               $display("FAIL saturate_p%0d[%0d] got %0d want %0d", pass, i, got, want);
            end
         end
      end
   endtask

   // RAM still holds non-silent words from earlier tests, so a broken fill
   // guard shows up as non-512 output in the first 15 samples.
   task automatic test_fill_wrap();
      logic [9:0] got, want;
      int lat;
      do_reset();
      delay = 4'd15; gain_sh = 2'd1; bypass = 1'b0;
      for (int i = 0; i < 41; i++) begin
         want = 10'd512;
         if (i == 20) want = 10'd600;
         if (i == 35) want = 10'd556;
         exp_q.push_back(want);
         drive_sample(i == 20 ? 10'd600 : 10'd512, got, lat);
         want = exp_q.pop_front();
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL fill_wrap[%0d] got %0d want %0d", i, got, want);
         end
      end
   endtask

   task automatic test_overrun();
      int n_ov, at_cyc;
      logic [9:0] got, want;
      int lat;
      do_reset();
      delay = 4'd0; gain_sh = 2'd0; bypass = 1'b0;
      exp_q.push_back(10'd600);
      n_ov = 0; at_cyc = -1; got = 'x;
      @(negedge sysclk);
      data_in = 10'd600; data_valid = 1'b1;          // accepted at edge 0
      for (int c = 0; c < 10; c++) begin
         @(negedge sysclk);                          // negedge after edge c
         data_valid = 1'b0;
         if (c == 1) begin
            data_in = 10'd700; data_valid = 1'b1;    // lands at edge 2
         end
         if (out_valid) begin
            n_ov++;
            at_cyc = c;
            got = data_out;
         end
      end
      n_cmp++;
      if (n_ov !== 1 || at_cyc !== 4) begin
         n_bad++;
         $display("FAIL overrun_strobe got %0d pulses at cycle %0d want 1 at cycle 4", n_ov, at_cyc);
      end
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL overrun_data got %0d want %0d", got, want);
      end
      n_cmp++;
      if (overrun !== 1'b1) begin
         n_bad++;
         $display("FAIL overrun_flag got %b want 1", overrun);
      end
      exp_q.push_back(10'd530);
      drive_sample(10'd530, got, lat);
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL overrun_next_sample got %0d want %0d", got, want);
      end
      n_cmp++;
      if (overrun !== 1'b1) begin
         n_bad++;
         $display("FAIL overrun_sticky got %b want 1", overrun);
      end
   endtask

   task automatic test_reset_mid_calc();
      int n_ov;
      do_reset();
      delay = 4'd0; gain_sh = 2'd0; bypass = 1'b0;
      n_ov = 0;
      @(negedge sysclk);
      data_in = 10'd700; data_valid = 1'b1;          // accepted at edge T
      @(negedge sysclk);                             // after T: RD
      data_valid = 1'b0;
      @(negedge sysclk);                             // after T+1: WT
      if (out_valid) n_ov++;
      @(negedge sysclk);                             // after T+2: CALC
      if (out_valid) n_ov++;
      rst_n = 1'b0;
      repeat (2) begin
         @(negedge sysclk);
         if (out_valid) n_ov++;
      end
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge sysclk);
         if (out_valid) n_ov++;
      end
      n_cmp++;
      if (n_ov !== 0) begin
         n_bad++;
         $display("FAIL midreset_out_valid got %0d pulses want 0", n_ov);
      end
      n_cmp++;
      if (data_out !== 10'd512) begin
         n_bad++;
         $display("FAIL midreset_data_out got %0d want 512", data_out);
      end
      n_cmp++;
      if (overrun !== 1'b0) begin
         n_bad++;
         $display("FAIL midreset_overrun got %b want 0", overrun);
      end
   endtask

   task automatic test_bypass();
      logic [9:0] got, want;
      int lat;
      do_reset();
      delay = 4'd2; gain_sh = 2'd0; bypass = 1'b1;
      exp_q.push_back(10'd700);
      drive_sample(10'd700, got, lat);
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL bypass_data got %0d want %0d", got, want);
      end
      n_cmp++;
      if (lat !== 4) begin
         n_bad++;
         $display("FAIL bypass_latency got %0d want 4", lat);
      end
      @(negedge sysclk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL strobe_width got %b want 0 one cycle after strobe", out_valid);
      end
      bypass = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         exp_q.push_back(i == 2 ? 10'd700 : 10'd512);
         drive_sample(10'd512, got, lat);
         want = exp_q.pop_front();
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL bypass_release[%0d] got %0d want %0d", i, got, want);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      data_in = '0;
      data_valid = 1'b0;
      delay = '0;
      gain_sh = '0;
      bypass = 1'b0;
      test_reset();
      test_impulse();
      test_saturation();
      test_fill_wrap();
      test_overrun();
      test_reset_mid_calc();
      test_bypass();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
